// File: rtl/alu_sequencer.sv
// Issues opcodes to the external 16-bit ALU, looping shifts through acc; result after 1+max(shamt,1) edges.
// Holds res_valid/res_data stable until res_ready; op_ready only in IDLE, so no overlap between ops.
module alu_sequencer #(
   parameter int W   = 16,
   parameter int SHW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           op_valid,
   output logic           op_ready,
   input  logic [3:0]     op,
   input  logic [W-1:0]   src_a,
   input  logic [W-1:0]   src_b,
   input  logic [SHW-1:0] shamt,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic           alu_ci,
   output logic           alu_nb,
   output logic           alu_ic,
   output logic           alu_na,
   output logic           alu_xo,
   output logic           alu_no,
   output logic           alu_sr,
   output logic           alu_ss,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_co,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [W-1:0]   res_data,
   output logic           res_carry,
   output logic           res_err
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_ADC = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     op_r;
   logic [W-1:0]   acc, breg;
   logic [SHW-1:0] cnt;
   logic           cf;
   logic           is_shift, zero_shift, last_cycle, is_logic, op_illegal;
   logic           exec_carry;

   assign is_shift   = (op_r == OP_SHL) || (op_r == OP_SRL) || (op_r == OP_SRA);
   assign is_logic   = (op_r == OP_AND) || (op_r == OP_OR) || (op_r == OP_XOR) || (op_r == OP_NOT);
   assign zero_shift = is_shift && (cnt == '0);
   assign last_cycle = !is_shift || (cnt <= SHW'(1));
   assign op_illegal = (op > OP_ADC);
   assign op_ready   = (state == S_IDLE);
   assign alu_a      = acc;

   always_comb begin
      state_nxt  = state;
      alu_b      = '0;
      alu_ci     = 1'b0;
      alu_nb     = 1'b0;
      alu_ic     = 1'b0;
      alu_na     = 1'b0;
      alu_xo     = 1'b0;
      alu_no     = 1'b0;
      alu_sr     = 1'b0;
      alu_ss     = 1'b0;
      exec_carry = 1'b0;
      case (state)
         S_IDLE: begin
            if (op_valid) state_nxt = op_illegal ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            if (last_cycle) state_nxt = S_DONE;
            if (zero_shift) begin
               // shamt=0 passes a through the logic path (a ^ 0)
               alu_ic = 1'b1;
            end else begin
               case (op_r)
                  OP_ADD: begin alu_b = breg; exec_carry = alu_co; end
                  OP_SUB: begin alu_b = breg; alu_ci = 1'b1; alu_nb = 1'b1; exec_carry = alu_co; end
                  OP_ADC: begin alu_b = breg; alu_ci = cf; exec_carry = alu_co; end
                  OP_AND: begin
                     alu_b = breg; alu_ic = 1'b1; alu_na = 1'b1; alu_nb = 1'b1;
                     alu_xo = 1'b1; alu_no = 1'b1;
                  end
                  OP_OR:  begin alu_b = breg; alu_ic = 1'b1; alu_xo = 1'b1; end
                  OP_XOR: begin alu_b = breg; alu_ic = 1'b1; end
                  OP_NOT: begin alu_ic = 1'b1; alu_na = 1'b1; end
                  OP_SHL: begin alu_b = acc; exec_carry = alu_co; end
                  OP_SRL: begin alu_ic = 1'b1; alu_sr = 1'b1; exec_carry = acc[0]; end
                  OP_SRA: begin alu_ic = 1'b1; alu_sr = 1'b1; alu_ss = 1'b1; exec_carry = acc[0]; end
                  default: ;
               endcase
            end
         end
         S_DONE: begin
            if (res_valid && res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_r      <= '0;
         acc       <= '0;
         breg      <= '0;
         cnt       <= '0;
         cf        <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  op_r      <= op;
                  acc       <= src_a;
                  breg      <= src_b;
                  cnt       <= shamt;
                  res_err   <= op_illegal;
                  res_carry <= 1'b0;
               end
            end
            S_EXEC: begin
               acc <= alu_out;
               if (!last_cycle) cnt <= cnt - SHW'(1);
               if (last_cycle) begin
                  res_carry <= exec_carry;
                  if (!is_logic) cf <= exec_carry;
               end
            end
            S_DONE: begin
               // first DONE cycle publishes the result; it then holds until the handshake
               if (!res_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= res_err ? '0 : acc;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural model of the ALU pins; directed vector table plus
// handwritten hold and mid-op reset sequences.
module tb_alu_sequencer;
   localparam int W = 16;
   localparam int SHW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           op_valid, op_ready;
   logic [3:0]     op;
   logic [W-1:0]   src_a, src_b;
   logic [SHW-1:0] shamt;
   logic [W-1:0]   alu_a, alu_b, alu_out;
   logic           alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss, alu_co;
   logic           res_valid, res_ready, res_carry, res_err;
   logic [W-1:0]   res_data;

   int errors = 0;
   int checks = 0;

   alu_sequencer #(.W(W), .SHW(SHW)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .src_a(src_a), .src_b(src_b), .shamt(shamt),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_ci(alu_ci), .alu_nb(alu_nb), .alu_ic(alu_ic), .alu_na(alu_na),
      .alu_xo(alu_xo), .alu_no(alu_no), .alu_sr(alu_sr), .alu_ss(alu_ss),
      .alu_out(alu_out), .alu_co(alu_co),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_carry(res_carry), .res_err(res_err)
   );

   always #5 clk = ~clk;

   // ALU model: ic=0 adds (with optional inversions and carry-in), ic=1 logic or shift-right
   logic [W-1:0] m_a, m_b, m_sum, m_lg;
   logic         m_co;
   always_comb begin
      m_a = alu_na ? ~alu_a : alu_a;
      m_b = alu_nb ? ~alu_b : alu_b;
      {m_co, m_sum} = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, alu_ci};
      m_lg = alu_xo ? (m_a | m_b) : (m_a ^ m_b);
      if (!alu_ic) begin
         alu_out = m_sum;
         alu_co  = m_co;
      end else if (alu_sr) begin
         alu_out = {alu_ss & m_a[W-1], m_a[W-1:1]};
         alu_co  = m_a[0];
      end else begin
         alu_out = alu_no ? ~m_lg : m_lg;
         alu_co  = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh, output logic [W-1:0] d, output logic c,
                         output logic e, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!op_ready && guard < 60) begin @(negedge clk); guard++; end
      op = o; src_a = a; src_b = b; shamt = sh; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 60) begin @(negedge clk); lat++; end
      d = res_data; c = res_carry; e = res_err;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   typedef struct {
      logic [3:0]     op;
      logic [W-1:0]   a, b;
      logic [SHW-1:0] sh;
      logic [W-1:0]   d;
      logic           c, e;
      int             lat;
   } vec_t;

   vec_t vec [19];

   initial begin
      logic [W-1:0] d;
      logic         c, e;
      int           lat;

      vec[0]  = '{4'd0,  16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b0, 2};  // ADD wraps, cf=1
      vec[1]  = '{4'd9,  16'h0000, 16'h0000, 4'd0, 16'h0001, 1'b0, 1'b0, 2};  // ADC uses cf
      vec[2]  = '{4'd1,  16'h0005, 16'h0007, 4'd0, 16'hFFFE, 1'b0, 1'b0, 2};  // SUB borrow
      vec[3]  = '{4'd2,  16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1'b0, 1'b0, 2};
      vec[4]  = '{4'd3,  16'hF0F0, 16'h3C3C, 4'd0, 16'hFCFC, 1'b0, 1'b0, 2};
      vec[5]  = '{4'd4,  16'hF0F0, 16'h3C3C, 4'd0, 16'hCCCC, 1'b0, 1'b0, 2};
      vec[6]  = '{4'd5,  16'h00FF, 16'h1234, 4'd0, 16'hFF00, 1'b0, 1'b0, 2};
      vec[7]  = '{4'd8,  16'h8004, 16'h0000, 4'd3, 16'hF000, 1'b1, 1'b0, 4};
      vec[8]  = '{4'd7,  16'h8004, 16'h0000, 4'd3, 16'h1000, 1'b1, 1'b0, 4};
      vec[9]  = '{4'd6,  16'h4001, 16'hAAAA, 4'd2, 16'h0004, 1'b1, 1'b0, 3};  // cf=1
      vec[10] = '{4'd12, 16'h1111, 16'h2222, 4'd1, 16'h0000, 1'b0, 1'b1, 1};  // illegal, cf kept
      vec[11] = '{4'd9,  16'h0010, 16'h0001, 4'd0, 16'h0012, 1'b0, 1'b0, 2};  // cf still 1
      vec[12] = '{4'd6,  16'h1234, 16'h5555, 4'd0, 16'h1234, 1'b0, 1'b0, 2};  // shamt=0, cf=0
      vec[13] = '{4'd9,  16'h0000, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 2};
      vec[14] = '{4'd1,  16'h0000, 16'h0000, 4'd0, 16'h0000, 1'b1, 1'b0, 2};  // cf=1
      vec[15] = '{4'd2,  16'hFFFF, 16'h0F0F, 4'd0, 16'h0F0F, 1'b0, 1'b0, 2};  // logic keeps cf
      vec[16] = '{4'd9,  16'h0001, 16'h0001, 4'd0, 16'h0003, 1'b0, 1'b0, 2};
      vec[17] = '{4'd8,  16'h7FFF, 16'h0000, 4'd15, 16'h0000, 1'b1, 1'b0, 16};
      vec[18] = '{4'd7,  16'hFFFF, 16'h0000, 4'd15, 16'h0001, 1'b1, 1'b0, 16};

      rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
      op = '0; src_a = '0; src_b = '0; shamt = '0;
      repeat (2) @(negedge clk);
      chk("reset res_valid", 32'(res_valid), 32'd0);
      chk("reset res_data", 32'(res_data), 32'd0);
      chk("reset op_ready", 32'(op_ready), 32'd1);
      chk("reset alu_a", 32'(alu_a), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         run_op(vec[i].op, vec[i].a, vec[i].b, vec[i].sh, d, c, e, lat);
         chk($sformatf("vec%0d data", i), 32'(d), 32'(vec[i].d));
         chk($sformatf("vec%0d carry", i), 32'(c), 32'(vec[i].c));
         chk($sformatf("vec%0d err", i), 32'(e), 32'(vec[i].e));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vec[i].lat));
      end

      // consumer stalls: result held, new requests ignored
      @(negedge clk);
      op = 4'd0; src_a = 16'h0001; src_b = 16'h0002; shamt = '0; op_valid = 1'b1;
      @(negedge clk);
      op = 4'd4; src_a = 16'hBEEF; src_b = 16'hCAFE;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d valid", k), 32'(res_valid), 32'd1);
         chk($sformatf("hold%0d data", k), 32'(res_data), 32'h0003);
         chk($sformatf("hold%0d op_ready", k), 32'(op_ready), 32'd0);
         @(negedge clk);
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("post-hold valid cleared", 32'(res_valid), 32'd0);
      chk("post-hold op_ready", 32'(op_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("no spurious result", 32'(res_valid), 32'd0);

      // leave cf=1, then abort a long SRL with reset
      run_op(4'd0, 16'hFFFF, 16'h0001, 4'd0, d, c, e, lat);
      chk("pre-reset carry", 32'(c), 32'd1);
      @(negedge clk);
      op = 4'd7; src_a = 16'hFFFF; src_b = '0; shamt = 4'd15; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid-shift busy", 32'(op_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort res_valid", 32'(res_valid), 32'd0);
      chk("abort res_data", 32'(res_data), 32'd0);
      chk("abort res_carry", 32'(res_carry), 32'd0);
      chk("abort res_err", 32'(res_err), 32'd0);
      chk("abort op_ready", 32'(op_ready), 32'd1);
      chk("abort alu_a", 32'(alu_a), 32'd0);
      chk("abort controls", 32'({alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd9, 16'h0004, 16'h0005, 4'd0, d, c, e, lat);
      chk("after reset ADC data", 32'(d), 32'h0009);
      chk("after reset ADC carry", 32'(c), 32'd0);
      chk("after reset ADC latency", 32'(lat), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
